// File: rtl/itlb_refill_ctrl.sv
// ITLB refill controller: detects lookup misses, issues page-table walks, picks a
// victim entry and drives the tag-array write port. Owns entry valid bits and RR pointer.
module itlb_refill_ctrl #(
  parameter int unsigned ENTRY_NUM = 8,
  parameter int unsigned VPN_WD    = 27,
  parameter int unsigned ASID_WD   = 16,
  parameter int unsigned PPN_WD    = 44
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 tlb_flush_i,
  input  logic                 lookup_valid_i,
  input  logic [VPN_WD-1:0]    lookup_vpn_i,
  input  logic [ASID_WD-1:0]   lookup_asid_i,
  input  logic [ENTRY_NUM-1:0] entry_hit_i,
  output logic                 ptw_req_valid_o,
  input  logic                 ptw_req_ready_i,
  output logic [VPN_WD-1:0]    ptw_req_vpn_o,
  output logic [ASID_WD-1:0]   ptw_req_asid_o,
  input  logic                 ptw_resp_valid_i,
  input  logic                 ptw_resp_fault_i,
  input  logic [PPN_WD-1:0]    ptw_resp_ppn_i,
  input  logic                 ptw_resp_g_i,
  output logic [ENTRY_NUM-1:0] write_en_o,
  output logic [VPN_WD-1:0]    write_vpn_o,
  output logic [ASID_WD-1:0]   write_asid_o,
  output logic [PPN_WD-1:0]    write_ppn_o,
  output logic                 write_g_o,
  output logic [ENTRY_NUM-1:0] entry_valid_o,
  output logic                 miss_busy_o,
  output logic                 fault_o
);

  localparam int unsigned IDX_WD = $clog2(ENTRY_NUM);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_WRITE} state_e;

  state_e               state_q, state_d;
  logic [VPN_WD-1:0]    vpn_q, vpn_d;
  logic [ASID_WD-1:0]   asid_q, asid_d;
  logic [PPN_WD-1:0]    ppn_q, ppn_d;
  logic                 g_q, g_d;
  logic [IDX_WD-1:0]    victim_q, victim_d;
  logic [IDX_WD-1:0]    rr_q, rr_d;
  logic [ENTRY_NUM-1:0] valid_q, valid_d;
  logic                 kill_q, kill_d;
  logic                 fault_q, fault_d;

  logic                 qual_hit;
  logic                 any_inv;
  logic [IDX_WD-1:0]    inv_idx;

  // Lowest-index invalid entry; scanning downward lets the lowest index win.
  always_comb begin
    any_inv = 1'b0;
    inv_idx = '0;
    for (int unsigned i = ENTRY_NUM; i > 0; i--) begin
      if (!valid_q[i-1]) begin
        any_inv = 1'b1;
        inv_idx = IDX_WD'(i-1);
      end
    end
  end

  assign qual_hit = |(entry_hit_i & valid_q);

  always_comb begin
    state_d  = state_q;
    vpn_d    = vpn_q;
    asid_d   = asid_q;
    ppn_d    = ppn_q;
    g_d      = g_q;
    victim_d = victim_q;
    rr_d     = rr_q;
    valid_d  = valid_q;
    fault_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (lookup_valid_i && !qual_hit && !tlb_flush_i) begin
          vpn_d   = lookup_vpn_i;
          asid_d  = lookup_asid_i;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (ptw_req_ready_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (ptw_resp_valid_i) begin
          if (kill_q || tlb_flush_i) begin
            state_d = S_IDLE;
          end else if (ptw_resp_fault_i) begin
            fault_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            ppn_d   = ptw_resp_ppn_i;
            g_d     = ptw_resp_g_i;
            state_d = S_WRITE;
            if (any_inv) begin
              victim_d = inv_idx;
            end else begin
              victim_d = rr_q;
              rr_d     = rr_q + IDX_WD'(1);
            end
          end
        end
      end
      S_WRITE: begin
        state_d = S_IDLE;
        if (!tlb_flush_i) valid_d[victim_q] = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (tlb_flush_i) begin
      valid_d = '0;
      rr_d    = '0;
    end
    kill_d = (state_d == S_IDLE) ? 1'b0 : (kill_q | tlb_flush_i);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= S_IDLE;
      vpn_q    <= '0;
      asid_q   <= '0;
      ppn_q    <= '0;
      g_q      <= 1'b0;
      victim_q <= '0;
      rr_q     <= '0;
      valid_q  <= '0;
      kill_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      vpn_q    <= vpn_d;
      asid_q   <= asid_d;
      ppn_q    <= ppn_d;
      g_q      <= g_d;
      victim_q <= victim_d;
      rr_q     <= rr_d;
      valid_q  <= valid_d;
      kill_q   <= kill_d;
      fault_q  <= fault_d;
    end
  end

  assign ptw_req_valid_o = (state_q == S_REQ);
  assign ptw_req_vpn_o   = vpn_q;
  assign ptw_req_asid_o  = asid_q;
  // Flush must cancel the write in the very cycle it arrives, so it gates the enable directly.
  assign write_en_o      = (state_q == S_WRITE && !tlb_flush_i) ?
                           ({{(ENTRY_NUM-1){1'b0}}, 1'b1} << victim_q) : '0;
  assign write_vpn_o     = vpn_q;
  assign write_asid_o    = asid_q;
  assign write_ppn_o     = ppn_q;
  assign write_g_o       = g_q;
  assign entry_valid_o   = valid_q;
  assign miss_busy_o     = (state_q != S_IDLE);
  assign fault_o         = fault_q;

endmodule

// File: tb/tb_itlb_refill_ctrl.sv
// Scoreboard bench for itlb_refill_ctrl: directed refills push expected PTW requests,
// writes and faults into queues; a negedge monitor pops and compares them.
module tb_itlb_refill_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        tlb_flush;
  logic        lookup_valid;
  logic [26:0] lookup_vpn;
  logic [15:0] lookup_asid;
  logic [7:0]  entry_hit;
  logic        ptw_req_valid_o;
  logic        ptw_req_ready;
  logic [26:0] ptw_req_vpn_o;
  logic [15:0] ptw_req_asid_o;
  logic        resp_valid;
  logic        resp_fault;
  logic [43:0] resp_ppn;
  logic        resp_g;
  logic [7:0]  write_en_o;
  logic [26:0] write_vpn_o;
  logic [15:0] write_asid_o;
  logic [43:0] write_ppn_o;
  logic        write_g_o;
  logic [7:0]  entry_valid_o;
  logic        miss_busy_o;
  logic        fault_o;

  always #5 clk = ~clk;

  itlb_refill_ctrl #(.ENTRY_NUM(8), .VPN_WD(27), .ASID_WD(16), .PPN_WD(44)) dut (
    .clk_i(clk), .rstn_i(rstn), .tlb_flush_i(tlb_flush),
    .lookup_valid_i(lookup_valid), .lookup_vpn_i(lookup_vpn), .lookup_asid_i(lookup_asid),
    .entry_hit_i(entry_hit),
    .ptw_req_valid_o(ptw_req_valid_o), .ptw_req_ready_i(ptw_req_ready),
    .ptw_req_vpn_o(ptw_req_vpn_o), .ptw_req_asid_o(ptw_req_asid_o),
    .ptw_resp_valid_i(resp_valid), .ptw_resp_fault_i(resp_fault),
    .ptw_resp_ppn_i(resp_ppn), .ptw_resp_g_i(resp_g),
    .write_en_o(write_en_o), .write_vpn_o(write_vpn_o), .write_asid_o(write_asid_o),
    .write_ppn_o(write_ppn_o), .write_g_o(write_g_o),
    .entry_valid_o(entry_valid_o), .miss_busy_o(miss_busy_o), .fault_o(fault_o)
  );

  typedef struct {
    logic [26:0] vpn;
    logic [15:0] asid;
  } req_t;

  typedef struct {
    logic [7:0]  en;
    logic [26:0] vpn;
    logic [15:0] asid;
    logic [43:0] ppn;
    logic        g;
  } wr_t;

  req_t        req_q[$];
  wr_t         wr_q[$];
  logic [26:0] flt_q[$];

  int unsigned checks   = 0;
  int unsigned failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s: DUT output with no expected entry at %0t", name, $time);
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (ptw_req_valid_o && ptw_req_ready) begin
        if (req_q.size() == 0) unexpected("ptw_req");
        else begin
          req_t r;
          r = req_q.pop_front();
          check("req_vpn", 64'(ptw_req_vpn_o), 64'(r.vpn));
          check("req_asid", 64'(ptw_req_asid_o), 64'(r.asid));
        end
      end
      if (write_en_o != 8'h00) begin
        if (wr_q.size() == 0) unexpected("write_en");
        else begin
          wr_t w;
          w = wr_q.pop_front();
          check("write_en", 64'(write_en_o), 64'(w.en));
          check("write_vpn", 64'(write_vpn_o), 64'(w.vpn));
          check("write_asid", 64'(write_asid_o), 64'(w.asid));
          check("write_ppn", 64'(write_ppn_o), 64'(w.ppn));
          check("write_g", 64'(write_g_o), 64'(w.g));
        end
      end
      if (fault_o) begin
        if (flt_q.size() == 0) unexpected("fault");
        else begin
          logic [26:0] fv;
          fv = flt_q.pop_front();
          check("fault_vpn", 64'(ptw_req_vpn_o), 64'(fv));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // flush_at: 0 none, 1 during WAIT before the response, 2 in the WRITE cycle
  task automatic refill(input logic [26:0] vpn, input logic [15:0] asid, input logic [7:0] hit,
                        input int unsigned delay, input logic [43:0] ppn, input logic g,
                        input logic flt, input logic [7:0] victim_oh,
                        input int unsigned flush_at, input logic [7:0] exp_valid);
    req_t r;
    wr_t  w;
    r.vpn = vpn; r.asid = asid;
    req_q.push_back(r);
    lookup_valid = 1'b1; lookup_vpn = vpn; lookup_asid = asid; entry_hit = hit;
    tick();
    lookup_valid = 1'b0; entry_hit = 8'h00; lookup_vpn = 27'h7ffffff;
    check("req_valid_t1", 64'(ptw_req_valid_o), 64'd1);
    check("busy_t1", 64'(miss_busy_o), 64'd1);
    for (int i = 0; i < int'(delay); i++) begin
      check("req_stable_valid", 64'(ptw_req_valid_o), 64'd1);
      check("req_stable_vpn", 64'(ptw_req_vpn_o), 64'(vpn));
      check("req_stable_asid", 64'(ptw_req_asid_o), 64'(asid));
      tick();
    end
    check("req_valid_hs", 64'(ptw_req_valid_o), 64'd1);
    ptw_req_ready = 1'b1;
    tick();
    ptw_req_ready = 1'b0;
    check("req_dropped", 64'(ptw_req_valid_o), 64'd0);
    if (flush_at == 1) begin
      tlb_flush = 1'b1;
      tick();
      tlb_flush = 1'b0;
      check("flush_wait_busy", 64'(miss_busy_o), 64'd1);
    end
    resp_valid = 1'b1; resp_fault = flt; resp_ppn = ppn; resp_g = g;
    if (flush_at == 0 && flt) flt_q.push_back(vpn);
    if (flush_at == 0 && !flt) begin
      w.en = victim_oh; w.vpn = vpn; w.asid = asid; w.ppn = ppn; w.g = g;
      wr_q.push_back(w);
    end
    tick();
    resp_valid = 1'b0; resp_fault = 1'b0; resp_ppn = '0; resp_g = 1'b0;
    if (flush_at == 1) begin
      check("killed_idle", 64'(miss_busy_o), 64'd0);
      check("killed_nofault", 64'(fault_o), 64'd0);
    end else if (flt) begin
      check("fault_r1", 64'(fault_o), 64'd1);
      check("fault_busy", 64'(miss_busy_o), 64'd0);
      tick();
      check("fault_r2", 64'(fault_o), 64'd0);
    end else begin
      check("write_busy", 64'(miss_busy_o), 64'd1);
      if (flush_at == 2) begin
        tlb_flush = 1'b1;
        #1;
        check("flush_write_en", 64'(write_en_o), 64'd0);
        tick();
        tlb_flush = 1'b0;
      end else begin
        tick();
      end
    end
    check("done_busy", 64'(miss_busy_o), 64'd0);
    check("entry_valid", 64'(entry_valid_o), 64'(exp_valid));
  endtask

  task automatic hit_probe(input logic [7:0] hit);
    lookup_valid = 1'b1; lookup_vpn = 27'h0333; lookup_asid = 16'h0003; entry_hit = hit;
    tick();
    lookup_valid = 1'b0; entry_hit = 8'h00;
    check("hit_no_req", 64'(ptw_req_valid_o), 64'd0);
    check("hit_no_busy", 64'(miss_busy_o), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rstn = 1'b0; tlb_flush = 1'b0; lookup_valid = 1'b0; lookup_vpn = '0; lookup_asid = '0;
    entry_hit = '0; ptw_req_ready = 1'b0; resp_valid = 1'b0; resp_fault = 1'b0;
    resp_ppn = '0; resp_g = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(entry_valid_o), 64'd0);
    check("rst_wen", 64'(write_en_o), 64'd0);
    check("rst_req", 64'(ptw_req_valid_o), 64'd0);
    check("rst_fault", 64'(fault_o), 64'd0);
    check("rst_busy", 64'(miss_busy_o), 64'd0);
    check("rst_req_vpn", 64'(ptw_req_vpn_o), 64'd0);
    check("rst_wr_ppn", 64'(write_ppn_o), 64'd0);
    rstn = 1'b1;
    tick();

    // Cold miss, then fill 1..7 and wrap onto entries 0 and 1
    refill(27'h1234, 16'h0001, 8'h00, 0, 44'hABC, 1'b0, 1'b0, 8'h01, 0, 8'h01);
    refill(27'h1001, 16'h0001, 8'h00, 0, 44'h101, 1'b1, 1'b0, 8'h02, 0, 8'h03);
    refill(27'h1002, 16'h0002, 8'h00, 0, 44'h102, 1'b0, 1'b0, 8'h04, 0, 8'h07);
    refill(27'h1003, 16'h0003, 8'h00, 0, 44'h103, 1'b0, 1'b0, 8'h08, 0, 8'h0F);
    refill(27'h1004, 16'h0004, 8'h00, 0, 44'h104, 1'b1, 1'b0, 8'h10, 0, 8'h1F);
    refill(27'h1005, 16'h0005, 8'h00, 0, 44'h105, 1'b0, 1'b0, 8'h20, 0, 8'h3F);
    refill(27'h1006, 16'h0006, 8'h00, 0, 44'h106, 1'b0, 1'b0, 8'h40, 0, 8'h7F);
    refill(27'h1007, 16'h0007, 8'h00, 0, 44'h107, 1'b0, 1'b0, 8'h80, 0, 8'hFF);
    refill(27'h1008, 16'h0008, 8'h00, 0, 44'h108, 1'b0, 1'b0, 8'h01, 0, 8'hFF);
    refill(27'h1009, 16'h0009, 8'h00, 0, 44'h109, 1'b1, 1'b0, 8'h02, 0, 8'hFF);

    // Fault leaves valid bits and pointer alone; back-pressure then uses pointer value 2
    refill(27'h2000, 16'h0020, 8'h00, 0, 44'h200, 1'b0, 1'b1, 8'h00, 0, 8'hFF);
    refill(27'h3abc, 16'hbeef, 8'h00, 5, 44'hFEDCBA98765, 1'b1, 1'b0, 8'h04, 0, 8'hFF);

    // Flush in IDLE together with a miss: flush wins, nothing latched
    tlb_flush = 1'b1; lookup_valid = 1'b1; lookup_vpn = 27'h4444;
    tick();
    tlb_flush = 1'b0; lookup_valid = 1'b0;
    check("idle_flush_valid", 64'(entry_valid_o), 64'd0);
    check("idle_flush_noreq", 64'(ptw_req_valid_o), 64'd0);

    // Hit suppression
    refill(27'h0500, 16'h0005, 8'h00, 0, 44'h500, 1'b0, 1'b0, 8'h01, 0, 8'h01);
    refill(27'h0501, 16'h0005, 8'h00, 0, 44'h501, 1'b0, 1'b0, 8'h02, 0, 8'h03);
    refill(27'h0502, 16'h0005, 8'h00, 0, 44'h502, 1'b0, 1'b0, 8'h04, 0, 8'h07);
    refill(27'h0503, 16'h0005, 8'h00, 0, 44'h503, 1'b0, 1'b0, 8'h08, 0, 8'h0F);
    hit_probe(8'h08);
    refill(27'h0504, 16'h0005, 8'h10, 0, 44'h504, 1'b0, 1'b0, 8'h10, 0, 8'h1F);

    // Flush during WAIT, then flush in the WRITE cycle; each followed by a miss into entry 0
    refill(27'h0600, 16'h0006, 8'h00, 1, 44'h600, 1'b0, 1'b0, 8'h00, 1, 8'h00);
    refill(27'h0601, 16'h0006, 8'h00, 0, 44'h601, 1'b0, 1'b0, 8'h01, 0, 8'h01);
    refill(27'h0602, 16'h0006, 8'h00, 0, 44'h602, 1'b0, 1'b0, 8'h00, 2, 8'h00);
    refill(27'h0603, 16'h0006, 8'h00, 0, 44'h603, 1'b1, 1'b0, 8'h01, 0, 8'h01);

    repeat (3) tick();
    check("req_q_empty", 64'(req_q.size()), 64'd0);
    check("wr_q_empty", 64'(wr_q.size()), 64'd0);
    check("flt_q_empty", 64'(flt_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
